// File: rtl/nbody_sched_pkg.sv
// Shared state encoding and default widths for the N-body step scheduler.
package nbody_sched_pkg;

    localparam int unsigned DEF_ADDR_LEN = 12;
    localparam int unsigned DEF_CYC_W    = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_BCAST  = 3'd2,
        ST_UPDATE = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

endpackage

// File: rtl/sched_ack_collector.sv
// Sticky per-town acknowledge capture; all_set also sees bits arriving this cycle.
module sched_ack_collector #(
    parameter int unsigned NUM_TOWNS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic [NUM_TOWNS-1:0] bits,
    output logic                 all_set
);

    logic [NUM_TOWNS-1:0] seen_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            seen_q <= '0;
        end else begin
            seen_q <= seen_q | bits;
        end
    end

    assign all_set = &(seen_q | bits);

endmodule

// File: rtl/nbody_step_scheduler.sv
// Sequences one N-body timestep: visitor broadcast, town update, done report.
// Optional per-phase watchdog enabled by defining STEP_TIMEOUT_EN.
module nbody_step_scheduler
    import nbody_sched_pkg::*;
#(
    parameter int unsigned NUM_TOWNS      = 4,
    parameter int unsigned ADDR_LEN       = DEF_ADDR_LEN,
    parameter int unsigned CYC_W          = DEF_CYC_W,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic [ADDR_LEN-1:0]  i_num_visitors,
    output logic [ADDR_LEN-1:0]  o_visitor_addr,
    output logic                 o_visitor_valid,
    input  logic [NUM_TOWNS-1:0] i_town_ready,
    output logic                 o_last_visitor,
    output logic                 o_update_start,
    input  logic [NUM_TOWNS-1:0] i_update_done,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [CYC_W-1:0]     o_step_cycles,
    output logic                 o_timeout
);

    // One extra bit keeps count-1 from wrapping when count is zero.
    localparam int unsigned CMP_W = ADDR_LEN + 1;

    state_e              state_q, state_d;
    logic [ADDR_LEN-1:0] addr_q, addr_d;
    logic [ADDR_LEN-1:0] count_q, count_d;
    logic [CYC_W-1:0]    cyc_q, cyc_d;
    logic                in_step, last_addr, upd_clr, upd_all;
    logic                valid_d, last_d, upd_start_d, busy_d, done_d;

    sched_ack_collector #(.NUM_TOWNS(NUM_TOWNS)) u_update_collector (
        .clk     (i_clk),
        .rst     (i_rst),
        .clr     (upd_clr),
        .bits    (i_update_done),
        .all_set (upd_all)
    );

`ifdef STEP_TIMEOUT_EN
    localparam int unsigned PH_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [PH_W-1:0] phase_q;
    logic            phase_exp;
    logic            timeout_q, timeout_d;

    assign phase_exp = (phase_q == PH_W'(TIMEOUT_CYCLES - 1));

    // Phase watchdog restarts whenever BCAST or UPDATE is (re)entered.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            phase_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_d;
            if (state_d != state_q) begin
                phase_q <= '0;
            end else if (state_q == ST_BCAST || state_q == ST_UPDATE) begin
                phase_q <= phase_q + PH_W'(1);
            end
        end
    end

    assign o_timeout = timeout_q;
`else
    assign o_timeout = 1'b0;
`endif

    assign in_step   = (state_q == ST_FETCH) || (state_q == ST_BCAST) || (state_q == ST_UPDATE);
    assign last_addr = (CMP_W'(addr_q) == CMP_W'(count_q) - CMP_W'(1));

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        cyc_d   = cyc_q;
        upd_clr = 1'b0;
`ifdef STEP_TIMEOUT_EN
        timeout_d = timeout_q;
`endif
        if (in_step && (cyc_q != '1)) begin
            cyc_d = cyc_q + CYC_W'(1);
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (i_start) begin
                    count_d = i_num_visitors;
                    addr_d  = '0;
                    cyc_d   = CYC_W'(1);
`ifdef STEP_TIMEOUT_EN
                    timeout_d = 1'b0;
`endif
                    state_d = (i_num_visitors == '0) ? ST_DONE : ST_FETCH;
                end
            end
            ST_FETCH: state_d = ST_BCAST;
            ST_BCAST: begin
                if (&i_town_ready) begin
                    if (last_addr) begin
                        state_d = ST_UPDATE;
                        upd_clr = 1'b1;
                    end else begin
                        addr_d  = addr_q + ADDR_LEN'(1);
                        state_d = ST_FETCH;
                    end
                end
`ifdef STEP_TIMEOUT_EN
                else if (phase_exp) begin
                    state_d   = ST_DONE;
                    timeout_d = 1'b1;
                end
`endif
            end
            ST_UPDATE: begin
                if (upd_all) begin
                    state_d = ST_DONE;
                end
`ifdef STEP_TIMEOUT_EN
                else if (phase_exp) begin
                    state_d   = ST_DONE;
                    timeout_d = 1'b1;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next-state values.
    assign valid_d     = (state_d == ST_BCAST);
    assign last_d      = valid_d && (CMP_W'(addr_d) == CMP_W'(count_d) - CMP_W'(1));
    assign upd_start_d = (state_d == ST_UPDATE) && (state_q != ST_UPDATE);
    assign busy_d      = (state_d == ST_FETCH) || (state_d == ST_BCAST) || (state_d == ST_UPDATE);
    assign done_d      = (state_d == ST_DONE);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q         <= ST_IDLE;
            addr_q          <= '0;
            count_q         <= '0;
            cyc_q           <= '0;
            o_visitor_valid <= 1'b0;
            o_last_visitor  <= 1'b0;
            o_update_start  <= 1'b0;
            o_busy          <= 1'b0;
            o_done          <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            count_q         <= count_d;
            cyc_q           <= cyc_d;
            o_visitor_valid <= valid_d;
            o_last_visitor  <= last_d;
            o_update_start  <= upd_start_d;
            o_busy          <= busy_d;
            o_done          <= done_d;
        end
    end

    assign o_visitor_addr = addr_q;
    assign o_step_cycles  = cyc_q;

endmodule

// File: tb/tb_nbody_step_scheduler.sv
// Self-checking bench: directed step table, randomized steps, reset abort.
module tb_nbody_step_scheduler;

    localparam int unsigned NT = 4;
    localparam int unsigned AL = 12;
    localparam int unsigned CW = 32;
    localparam int          BUDGET = 400;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AL-1:0] num_visitors;
    logic [AL-1:0] visitor_addr;
    logic          visitor_valid;
    logic [NT-1:0] town_ready;
    logic          last_visitor;
    logic          update_start;
    logic [NT-1:0] update_done;
    logic          busy;
    logic          done;
    logic [CW-1:0] step_cycles;
    logic          timeout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nbody_step_scheduler #(
        .NUM_TOWNS(NT), .ADDR_LEN(AL), .CYC_W(CW), .TIMEOUT_CYCLES(65535)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_start        (start),
        .i_num_visitors (num_visitors),
        .o_visitor_addr (visitor_addr),
        .o_visitor_valid(visitor_valid),
        .i_town_ready   (town_ready),
        .o_last_visitor (last_visitor),
        .o_update_start (update_start),
        .i_update_done  (update_done),
        .o_busy         (busy),
        .o_done         (done),
        .o_step_cycles  (step_cycles),
        .o_timeout      (timeout)
    );

    typedef struct {
        int count;
        int rdy[NT];
        int dn[NT];
        bit glitch;
        int exp_cycles;
    } vec_t;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int count, input int r0, input int r1, input int r2,
                                input int r3, input int d0, input int d1, input int d2,
                                input int d3, input bit glitch, input int exp_cycles);
        vec_t v;
        v.count = count;
        v.rdy[0] = r0; v.rdy[1] = r1; v.rdy[2] = r2; v.rdy[3] = r3;
        v.dn[0]  = d0; v.dn[1]  = d1; v.dn[2]  = d2; v.dn[3]  = d3;
        v.glitch = glitch;
        v.exp_cycles = exp_cycles;
        return v;
    endfunction

    // Reference: each visitor costs one fetch cycle plus a broadcast lasting until
    // the slowest town is ready; update lasts until the slowest town reports done.
    function automatic int model_cycles(input vec_t v);
        int mr = 0;
        int md = 0;
        if (v.count == 0) return 1;
        for (int k = 0; k < NT; k++) begin
            if (v.rdy[k] > mr) mr = v.rdy[k];
            if (v.dn[k] > md) md = v.dn[k];
        end
        return 1 + v.count * (2 + mr) + (md + 1);
    endfunction

    task automatic run_step(input vec_t v, input string tag);
        int  accepts = 0;
        int  upd_pulses = 0;
        int  vcnt = 0;
        int  t = 0;
        int  cyc;
        bit  in_upd = 0;
        bit  seen_valid = 0;
        bit  done_seen = 0;

        @(negedge clk);
        start = 1'b1;
        num_visitors = AL'(v.count);
        @(negedge clk);
        start = 1'b0;
        num_visitors = AL'($urandom);
        check({tag, "_start_cycles"}, longint'(step_cycles), 1);
        if (v.count != 0) check({tag, "_start_busy"}, longint'({busy, done}), 2);

        for (cyc = 0; cyc < BUDGET; cyc++) begin
            if (cyc > 0) @(negedge clk);
            start = 1'b0;
            town_ready = '0;
            update_done = '0;
            if (done) begin
                done_seen = 1;
                break;
            end
            if (visitor_valid) begin
                seen_valid = 1;
                check({tag, "_addr"}, longint'(visitor_addr), accepts);
                check({tag, "_last"}, longint'(last_visitor), (accepts == v.count - 1) ? 1 : 0);
                if (v.glitch && accepts == 0 && vcnt == 0) begin
                    start = 1'b1;
                    num_visitors = AL'(v.count + 3);
                end
                for (int k = 0; k < NT; k++) town_ready[k] = (vcnt >= v.rdy[k]);
                if (&town_ready) accepts++;
                vcnt++;
            end else begin
                vcnt = 0;
            end
            if (update_start) begin
                upd_pulses++;
                in_upd = 1;
                t = 0;
            end
            if (in_upd) begin
                for (int k = 0; k < NT; k++) update_done[k] = (t == v.dn[k]);
                t++;
            end
        end

        check({tag, "_done_reached"}, done_seen, 1);
        if (v.count == 0) check({tag, "_zero_latency"}, cyc, 0);
        check({tag, "_step_cycles"}, longint'(step_cycles), v.exp_cycles);
        check({tag, "_accepts"}, accepts, v.count);
        check({tag, "_update_pulses"}, upd_pulses, (v.count != 0) ? 1 : 0);
        check({tag, "_valid_seen"}, seen_valid, (v.count != 0) ? 1 : 0);
        check({tag, "_idle_flags"}, longint'({busy, timeout}), 0);
    endtask

    task automatic reset_mid_bcast();
        bit hit = 0;
        bit stray = 0;
        @(negedge clk);
        start = 1'b1;
        num_visitors = AL'(8);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < BUDGET; i++) begin
            town_ready = visitor_valid ? '1 : '0;
            if (visitor_valid && visitor_addr == AL'(5)) begin
                town_ready = '0;
                hit = 1;
                break;
            end
            @(negedge clk);
        end
        check("rst_reached_addr5", hit, 1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_outputs_zero",
              longint'({visitor_addr, visitor_valid, last_visitor, update_start,
                        busy, done, step_cycles, timeout}), 0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (busy || done || update_start || visitor_valid) stray = 1;
        end
        check("rst_stays_idle", stray, 0);
    endtask

    vec_t tbl[6];

    initial begin
        rst = 1'b1;
        start = 1'b0;
        num_visitors = '0;
        town_ready = '0;
        update_done = '0;

        tbl[0] = mk(3, 1, 1, 1, 1, 2, 2, 2, 2, 0, 13);  // basic step
        tbl[1] = mk(2, 0, 0, 5, 0, 0, 0, 0, 0, 0, 16);  // town 2 backpressure
        tbl[2] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);   // zero bodies
        tbl[3] = mk(1, 0, 0, 0, 0, 1, 4, 4, 9, 0, 13);  // staggered update done
        tbl[4] = mk(2, 2, 2, 2, 2, 1, 1, 1, 1, 1, 11);  // start during BCAST ignored
        tbl[5] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4);   // restart from DONE

        repeat (3) @(negedge clk);
        check("reset_outputs_zero",
              longint'({visitor_addr, visitor_valid, last_visitor, update_start,
                        busy, done, step_cycles, timeout}), 0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) run_step(tbl[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 20; i++) begin
            vec_t v;
            v.count = int'($urandom_range(1, 6));
            for (int k = 0; k < NT; k++) begin
                v.rdy[k] = int'($urandom_range(0, 3));
                v.dn[k]  = int'($urandom_range(0, 8));
            end
            v.glitch = 1'($urandom_range(0, 1));
            v.exp_cycles = model_cycles(v);
            run_step(v, $sformatf("rnd%0d", i));
        end

        reset_mid_bcast();
        run_step(tbl[0], "after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nbody_step_scheduler.md
Name: nbody_step_scheduler

Overview:
Sequences one N-body timestep for the gravity engine. It latches a start from the HPS and walks the visitor address space one visitor at a time. Each visitor is broadcast to NUM_TOWNS neighborhoods, and the block waits for every town to accept it before advancing. After the last visitor it launches the town position-update phase, collects completion from every town, and reports done and the step cycle count back to the HPS.

Parameters:
NUM_TOWNS, 4, number of neighborhood/town units; width of the ready/done vectors
ADDR_LEN, 12, visitor address width; matches the visitor M10K address length
CYC_W, 32, width of the step cycle counter
TIMEOUT_CYCLES, 65535, watchdog limit per phase; used only with STEP_TIMEOUT_EN

Ports:
i_clk  in  1  single clock
i_rst  in  1  synchronous reset, active-high
i_start  in  1  HPS start pulse; ignored unless state is IDLE or DONE
i_num_visitors  in  ADDR_LEN  body count; sampled on accepted i_start
o_visitor_addr  out  ADDR_LEN  read address to the visitor memories
o_visitor_valid  out  1  visitor data on the memory outputs is valid for the towns
i_town_ready  in  NUM_TOWNS  per-town "consumed current visitor", level
o_last_visitor  out  1  high with o_visitor_valid when address == count-1
o_update_start  out  1  one-cycle pulse launching the update phase
i_update_done  in  NUM_TOWNS  per-town update-complete pulse or level
o_busy  out  1  high in FETCH, BCAST, UPDATE
o_done  out  1  high in DONE until the next accepted start or reset
o_step_cycles  out  CYC_W  cycles from accepted start to DONE entry, saturating
o_timeout  out  1  watchdog fired this step (tied 0 without the macro)

Behaviour:
- Reset: state IDLE. All outputs 0; internal address, count, cycle counter and collector cleared. Reset mid-step aborts immediately; no pulse is issued on reset exit.
- States: IDLE, FETCH, BCAST, UPDATE, DONE.
- IDLE / DONE + i_start:
  - Latch count = i_num_visitors, set addr = 0, clear o_done, o_timeout and o_step_cycles.
  - count == 0: go straight to DONE next cycle (o_step_cycles = 1, no o_update_start).
  - Otherwise go to FETCH.
- FETCH: exactly one cycle, covering the 1-cycle M10K read latency; o_visitor_valid = 0. Then go to BCAST.
- BCAST:
  - o_visitor_valid = 1; data is held stable because the address does not change.
  - Accept when &i_town_ready is high while valid.
  - On accept with addr < count-1: addr <= addr+1, go to FETCH; valid drops for the one FETCH cycle.
  - On accept with addr == count-1: go to UPDATE.
  - o_last_visitor = valid && (addr == count-1).
- UPDATE:
  - o_update_start pulses on the first UPDATE cycle only.
  - Collector bits are sticky-set by i_update_done and cleared on UPDATE entry; done bits arriving in the entry cycle still count.
  - When all NUM_TOWNS bits are set, go to DONE.
- DONE: o_done = 1 and o_step_cycles frozen. i_start here begins a new step directly.
- Cycle counter: increments every cycle in FETCH, BCAST and UPDATE, starting at 1 on the start-accept cycle, and saturates at all-ones. In a normal step, DONE-entry value = 2*count + update-wait cycles + 1.
- Width rule: the count-1 compare is done in ADDR_LEN+1 bits, so count == 0 never wraps to an all-ones last address.
- i_start while busy is ignored with no side effects. i_num_visitors changes after latch have no effect.

Optional Feature:
STEP_TIMEOUT_EN
- Defined: a per-phase counter resets on entry to BCAST or UPDATE. If the phase has not completed after TIMEOUT_CYCLES cycles, the state goes to DONE with o_timeout = 1. o_timeout is held until the next accepted start.
- Undefined: no watchdog logic; o_timeout is constant 0 and the block waits indefinitely.

Decomposition:
- Package nbody_sched_pkg holds:
  - state encoding constants: IDLE, FETCH, BCAST, UPDATE, DONE (3-bit);
  - the default ADDR_LEN and CYC_W values.
- Sub-module sched_ack_collector (parameter NUM_TOWNS):
  - sticky per-bit capture with a clear input;
  - outputs all_set.
  - It is reused for the update-done collection.

Test Plan:
- Basic step: count=3, towns ready 1 cycle after valid, update_done 2 cycles after pulse. Expect addr sequence 0,1,2; exactly 3 accepts; o_last_visitor only at addr 2; one o_update_start; o_done asserted.
- Backpressure: NUM_TOWNS=4, count=2; town 2 holds ready low for 5 cycles. Expect valid held with addr unchanged until all 4 are ready, then a single advance.
- Zero bodies: i_num_visitors=0. Expect DONE the next cycle, no valid or update pulse, o_step_cycles=1.
- Staggered update completion: towns pulse done in cycles 1, 4, 4 and 9 after o_update_start. Expect DONE entry only after the 9-cycle pulse, and only one o_update_start.
- Restart and ignore: i_start during BCAST is ignored. i_start in DONE with count=1 runs a new step, and o_step_cycles is cleared at start.
- Reset mid-BCAST at addr=5: expect all outputs 0 on the next cycle and state IDLE. With STEP_TIMEOUT_EN and TIMEOUT_CYCLES=10, towns never ready: expect DONE with o_timeout=1.
